// File: rtl/chroma_key_calibrator.sv
// chroma_key_calibrator
// Owns the packed {R,G,B} chroma-key threshold word. Thresholds come either
// from a manual load or from a one-frame calibration over a pixel window
// (max R + margin, min G - margin, max B + margin). Every new value is staged
// and only reaches the output filter on a frame_start, so the compositing
// stage never sees a threshold change mid-frame.
module chroma_key_calibrator #(
    parameter int unsigned R_WIDTH  = 5,
    parameter int unsigned G_WIDTH  = 6,
    parameter int unsigned B_WIDTH  = 5,
    parameter int unsigned X_WIDTH  = 11,
    parameter int unsigned Y_WIDTH  = 10,
    parameter int unsigned MARGIN_R = 1,
    parameter int unsigned MARGIN_G = 2,
    parameter int unsigned MARGIN_B = 1,
    localparam int unsigned PIXEL_SIZE = R_WIDTH + G_WIDTH + B_WIDTH,
    parameter logic [PIXEL_SIZE-1:0] RESET_FILTER = 16'h4508
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_start,
    input  logic [X_WIDTH-1:0]    i_pixel_x,
    input  logic [Y_WIDTH-1:0]    i_pixel_y,
    input  logic                  i_fg_pixel_ready,
    input  logic [PIXEL_SIZE-1:0] i_fg_pixel_in,
    input  logic [X_WIDTH-1:0]    i_win_x0,
    input  logic [X_WIDTH-1:0]    i_win_x1,
    input  logic [Y_WIDTH-1:0]    i_win_y0,
    input  logic [Y_WIDTH-1:0]    i_win_y1,
    input  logic                  i_cal_start,
    input  logic [PIXEL_SIZE-1:0] i_manual_filter_in,
    input  logic                  i_manual_filter_load,
    output logic [PIXEL_SIZE-1:0] o_ctrl_green_screen_filter,
    output logic                  o_cal_busy,
    output logic                  o_cal_done,
    output logic                  o_cal_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SAMPLE,
        ST_COMPUTE
    } state_t;

    state_t                r_state;
    logic [R_WIDTH-1:0]    r_max_r;
    logic [G_WIDTH-1:0]    r_min_g;
    logic [B_WIDTH-1:0]    r_max_b;
    logic [15:0]           r_count;
    logic [PIXEL_SIZE-1:0] r_pending;
    logic                  r_pending_valid;

    logic [R_WIDTH-1:0]    w_px_r;
    logic [G_WIDTH-1:0]    w_px_g;
    logic [B_WIDTH-1:0]    w_px_b;
    logic                  w_in_window;
    logic [R_WIDTH:0]      w_r_sum;
    logic [G_WIDTH:0]      w_g_diff;
    logic [B_WIDTH:0]      w_b_sum;
    logic [R_WIDTH-1:0]    w_r_thr;
    logic [G_WIDTH-1:0]    w_g_thr;
    logic [B_WIDTH-1:0]    w_b_thr;
    logic                  w_cal_stage;
    logic                  w_stage;
    logic [PIXEL_SIZE-1:0] w_stage_value;
    logic                  w_abort;

    assign w_px_r = i_fg_pixel_in[PIXEL_SIZE-1 -: R_WIDTH];
    assign w_px_g = i_fg_pixel_in[B_WIDTH +: G_WIDTH];
    assign w_px_b = i_fg_pixel_in[B_WIDTH-1:0];

    // Inclusive window test; an inverted window simply never matches.
    assign w_in_window = i_fg_pixel_ready
                      && (i_pixel_x >= i_win_x0) && (i_pixel_x <= i_win_x1)
                      && (i_pixel_y >= i_win_y0) && (i_pixel_y <= i_win_y1);

    // Threshold derivation: one extra bit catches overflow / borrow, then clamp.
    always_comb begin
        w_r_sum  = {1'b0, r_max_r} + (R_WIDTH+1)'(MARGIN_R);
        w_g_diff = {1'b0, r_min_g} - (G_WIDTH+1)'(MARGIN_G);
        w_b_sum  = {1'b0, r_max_b} + (B_WIDTH+1)'(MARGIN_B);
        w_r_thr  = w_r_sum[R_WIDTH]  ? '1 : w_r_sum[R_WIDTH-1:0];
        w_g_thr  = w_g_diff[G_WIDTH] ? '0 : w_g_diff[G_WIDTH-1:0];
        w_b_thr  = w_b_sum[B_WIDTH]  ? '1 : w_b_sum[B_WIDTH-1:0];
    end

    // A manual load always stages and takes priority over a calibration result.
    assign w_abort       = i_manual_filter_load && o_cal_busy;
    assign w_cal_stage   = (r_state == ST_COMPUTE) && (r_count != '0);
    assign w_stage       = i_manual_filter_load || w_cal_stage;
    assign w_stage_value = i_manual_filter_load ? i_manual_filter_in
                                                : {w_r_thr, w_g_thr, w_b_thr};

    // Staging register and frame-boundary commit of the active filter word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ctrl_green_screen_filter <= RESET_FILTER;
            r_pending                  <= '0;
            r_pending_valid            <= 1'b0;
        end else begin
            // Commit uses the old pending value; a same-cycle stage write
            // survives as the next pending value.
            if (i_frame_start && r_pending_valid) begin
                o_ctrl_green_screen_filter <= r_pending;
            end
            if (w_stage) begin
                r_pending       <= w_stage_value;
                r_pending_valid <= 1'b1;
            end else if (i_frame_start) begin
                r_pending_valid <= 1'b0;
            end
        end
    end

    // Calibration FSM with sample accumulators and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_max_r     <= '0;
            r_min_g     <= '1;
            r_max_b     <= '0;
            r_count     <= '0;
            o_cal_busy  <= 1'b0;
            o_cal_done  <= 1'b0;
            o_cal_error <= 1'b0;
        end else begin
            o_cal_done  <= 1'b0;
            o_cal_error <= 1'b0;
            if (w_abort) begin
                r_state    <= ST_IDLE;
                o_cal_busy <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_cal_start) begin
                            r_state    <= ST_ARM;
                            o_cal_busy <= 1'b1;
                        end
                    end
                    ST_ARM: begin
                        if (i_frame_start) begin
                            r_max_r <= '0;
                            r_min_g <= '1;
                            r_max_b <= '0;
                            r_count <= '0;
                            r_state <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        if (i_frame_start) begin
                            r_state <= ST_COMPUTE;
                        end else if (w_in_window) begin
                            if (w_px_r > r_max_r) r_max_r <= w_px_r;
                            if (w_px_g < r_min_g) r_min_g <= w_px_g;
                            if (w_px_b > r_max_b) r_max_b <= w_px_b;
                            if (r_count != '1) r_count <= r_count + 16'd1;
                        end
                    end
                    ST_COMPUTE: begin
                        r_state    <= ST_IDLE;
                        o_cal_busy <= 1'b0;
                        if (r_count == '0) begin
                            o_cal_error <= 1'b1;
                        end else begin
                            o_cal_done <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        o_cal_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chroma_key_calibrator.sv
// tb_chroma_key_calibrator
// Table-driven calibration vectors plus hand-written manual-load, abort and
// reset sequences. Expected filter words are queued when staged and popped
// at each frame_start commit.
module tb_chroma_key_calibrator;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_frame_start = 1'b0;
    logic [10:0] i_pixel_x = '0;
    logic [9:0]  i_pixel_y = '0;
    logic        i_fg_pixel_ready = 1'b0;
    logic [15:0] i_fg_pixel_in = '0;
    logic [10:0] i_win_x0 = '0;
    logic [10:0] i_win_x1 = '0;
    logic [9:0]  i_win_y0 = '0;
    logic [9:0]  i_win_y1 = '0;
    logic        i_cal_start = 1'b0;
    logic [15:0] i_manual_filter_in = '0;
    logic        i_manual_filter_load = 1'b0;
    logic [15:0] o_ctrl_green_screen_filter;
    logic        o_cal_busy;
    logic        o_cal_done;
    logic        o_cal_error;

    chroma_key_calibrator dut (
        .i_clk                      (i_clk),
        .i_rst                      (i_rst),
        .i_frame_start              (i_frame_start),
        .i_pixel_x                  (i_pixel_x),
        .i_pixel_y                  (i_pixel_y),
        .i_fg_pixel_ready           (i_fg_pixel_ready),
        .i_fg_pixel_in              (i_fg_pixel_in),
        .i_win_x0                   (i_win_x0),
        .i_win_x1                   (i_win_x1),
        .i_win_y0                   (i_win_y0),
        .i_win_y1                   (i_win_y1),
        .i_cal_start                (i_cal_start),
        .i_manual_filter_in         (i_manual_filter_in),
        .i_manual_filter_load       (i_manual_filter_load),
        .o_ctrl_green_screen_filter (o_ctrl_green_screen_filter),
        .o_cal_busy                 (o_cal_busy),
        .o_cal_done                 (o_cal_done),
        .o_cal_error                (o_cal_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [10:0] x0, x1;
        logic [9:0]  y0, y1;
        logic [15:0] pa, pb;     // in-window pixels, alternating
        logic [15:0] po;         // out-of-window pixel
        logic [15:0] exp_filt;
        bit          exp_err;
    } cal_vec_t;

    cal_vec_t    tbl[6];
    logic [15:0] sb_q[$];
    logic [15:0] cur_filt;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] pk(input int r, input int g, input int b);
        logic [31:0] rv, gv, bv;
        rv = r; gv = g; bv = b;
        return {rv[4:0], gv[5:0], bv[4:0]};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // frame_start pulse; an in-window garbage pixel is presented on the same
    // cycle and must not be sampled. Optionally loads a manual value as well.
    task automatic fs_check(input string name, input bit ld, input logic [15:0] v);
        logic [15:0] exp;
        i_frame_start    = 1'b1;
        i_fg_pixel_ready = 1'b1;
        i_pixel_x        = i_win_x0;
        i_pixel_y        = i_win_y0;
        i_fg_pixel_in    = pk(31, 0, 31);
        if (ld) begin
            i_manual_filter_load = 1'b1;
            i_manual_filter_in   = v;
        end
        step();
        i_frame_start        = 1'b0;
        i_fg_pixel_ready     = 1'b0;
        i_manual_filter_load = 1'b0;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : cur_filt;
        chk16(name, o_ctrl_green_screen_filter, exp);
        cur_filt = exp;
        if (ld) sb_q.push_back(v);
    endtask

    task automatic manual_load(input logic [15:0] v);
        i_manual_filter_load = 1'b1;
        i_manual_filter_in   = v;
        step();
        i_manual_filter_load = 1'b0;
        sb_q.push_back(v);
    endtask

    task automatic set_window(input cal_vec_t r);
        i_win_x0 = r.x0; i_win_x1 = r.x1;
        i_win_y0 = r.y0; i_win_y1 = r.y1;
    endtask

    // Raster over x 8..15, y 4..7, preceded by one not-ready garbage cycle.
    task automatic frame_pixels(input cal_vec_t r);
        int k;
        bit inw;
        k = 0;
        i_fg_pixel_ready = 1'b0;
        i_pixel_x        = r.x0;
        i_pixel_y        = r.y0;
        i_fg_pixel_in    = pk(31, 0, 31);
        step();
        for (int y = 4; y <= 7; y++) begin
            for (int x = 8; x <= 15; x++) begin
                inw = (x >= int'(r.x0)) && (x <= int'(r.x1)) && (y >= int'(r.y0)) && (y <= int'(r.y1));
                i_fg_pixel_ready = 1'b1;
                i_pixel_x        = 11'(x);
                i_pixel_y        = 10'(y);
                i_fg_pixel_in    = inw ? (k[0] ? r.pb : r.pa) : r.po;
                if (inw) k++;
                step();
            end
        end
        i_fg_pixel_ready = 1'b0;
    endtask

    task automatic count_pulses(input int cycles, output int nd, output int ne);
        nd = 0; ne = 0;
        for (int i = 0; i < cycles; i++) begin
            if (o_cal_done)  nd++;
            if (o_cal_error) ne++;
            step();
        end
    endtask

    task automatic run_cal(input cal_vec_t r);
        int nd, ne;
        set_window(r);
        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        chk_int("busy_arm", int'(o_cal_busy), 1);
        fs_check("filt_arm_fs", 1'b0, '0);
        chk_int("busy_sample", int'(o_cal_busy), 1);
        frame_pixels(r);
        fs_check("filt_end_fs", 1'b0, '0);
        count_pulses(4, nd, ne);
        chk_int("cal_done_cnt", nd, r.exp_err ? 0 : 1);
        chk_int("cal_err_cnt", ne, r.exp_err ? 1 : 0);
        chk_int("busy_after", int'(o_cal_busy), 0);
        if (!r.exp_err) sb_q.push_back(r.exp_filt);
        step();
        chk16("filt_hold_midframe", o_ctrl_green_screen_filter, cur_filt);
        fs_check("filt_commit", 1'b0, '0);
    endtask

    initial begin
        int nd, ne;
        tbl[0] = '{11'd10, 11'd13, 10'd5, 10'd6, pk(3, 50, 2),  pk(5, 45, 4),  pk(31, 0, 31), 16'h3565, 1'b0};
        tbl[1] = '{11'd10, 11'd13, 10'd5, 10'd6, pk(31, 1, 31), pk(31, 1, 31), pk(0, 63, 0),  16'hF81F, 1'b0};
        tbl[2] = '{11'd20, 11'd10, 10'd5, 10'd6, pk(1, 1, 1),   pk(1, 1, 1),   pk(31, 0, 31), 16'h0000, 1'b1};
        tbl[3] = '{11'd8,  11'd8,  10'd4, 10'd4, pk(0, 63, 0),  pk(0, 63, 0),  pk(31, 0, 31), 16'h0FA1, 1'b0};
        tbl[4] = '{11'd8,  11'd15, 10'd7, 10'd4, pk(1, 1, 1),   pk(1, 1, 1),   pk(31, 0, 31), 16'h0000, 1'b1};
        tbl[5] = '{11'd15, 11'd15, 10'd7, 10'd7, pk(16, 32, 10), pk(16, 32, 10), pk(31, 0, 31), 16'h8BCB, 1'b0};

        // Reset state
        step(); step();
        i_rst = 1'b0;
        cur_filt = 16'h4508;
        chk16("reset_filter", o_ctrl_green_screen_filter, 16'h4508);
        chk_int("reset_busy", int'(o_cal_busy), 0);
        chk_int("reset_done", int'(o_cal_done), 0);
        chk_int("reset_error", int'(o_cal_error), 0);
        for (int i = 0; i < 3; i++) begin
            fs_check("reset_fs_hold", 1'b0, '0);
            step(); step();
        end

        // Table-driven calibrations
        foreach (tbl[i]) run_cal(tbl[i]);

        // Manual load mid-frame commits only at the next frame_start
        step();
        manual_load(16'h1234);
        step();
        chk16("manual_hold", o_ctrl_green_screen_filter, cur_filt);
        fs_check("manual_commit", 1'b0, '0);

        // Load coinciding with a commit: old pending first, new one next frame
        step();
        manual_load(16'h0ABC);
        step();
        fs_check("coincide_old", 1'b1, 16'h1234);
        step(); step();
        fs_check("coincide_new", 1'b0, '0);

        // cal_start ignored while busy; manual load aborts the calibration
        set_window(tbl[0]);
        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        fs_check("abort_arm_fs", 1'b0, '0);
        step(); step();
        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        chk_int("busy_ignore_start", int'(o_cal_busy), 1);
        manual_load(16'h5555);
        chk_int("busy_abort", int'(o_cal_busy), 0);
        fs_check("abort_commit", 1'b0, '0);
        count_pulses(4, nd, ne);
        chk_int("abort_done_cnt", nd, 0);
        chk_int("abort_err_cnt", ne, 0);
        fs_check("abort_hold", 1'b0, '0);

        // Manual load in the COMPUTE cycle wins over the calibration result
        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        fs_check("cmp_arm_fs", 1'b0, '0);
        frame_pixels(tbl[0]);
        fs_check("cmp_end_fs", 1'b0, '0);
        manual_load(16'h7777);
        count_pulses(4, nd, ne);
        chk_int("cmp_done_cnt", nd, 0);
        chk_int("cmp_err_cnt", ne, 0);
        fs_check("cmp_commit", 1'b0, '0);
        step(); step();
        fs_check("cmp_hold", 1'b0, '0);

        // Reset mid-calibration drops pending value and FSM state
        manual_load(16'hAAAA);
        i_cal_start = 1'b1;
        step();
        i_cal_start = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        sb_q.delete();
        cur_filt = 16'h4508;
        chk16("rst_mid_filter", o_ctrl_green_screen_filter, 16'h4508);
        chk_int("rst_mid_busy", int'(o_cal_busy), 0);
        fs_check("rst_mid_fs", 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
